// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared types and defaults for the serial feeder
package serial_feeder_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int GAP_DEF   = 0;
    localparam int GAP_CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/serial_feeder_if.sv
// serial_feeder_if: parallel-in / serial-out bus of the serial feeder
interface serial_feeder_if
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             data;
    logic             data_valid;
    logic             busy;

    modport master (output din, din_valid, input din_ready, data, data_valid, busy);
    modport slave  (input din, din_valid, output din_ready, data, data_valid, busy);
endinterface

// File: rtl/serial_feeder_hold.sv
// serial_feeder_hold: one-word holding buffer in front of the shifter
module serial_feeder_hold
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             take,
    output logic [WIDTH-1:0] hold_q,
    output logic             hold_full,
    output logic             din_ready
);
    logic accept;

    assign din_ready = !hold_full;
    assign accept    = din_valid && !hold_full;

    // Flag set on a transfer, cleared when the shifter takes the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_full <= 1'b0;
        else if (accept)
            hold_full <= 1'b1;
        else if (take)
            hold_full <= 1'b0;
    end

    // Capture the word only in the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_q <= '0;
        else if (accept)
            hold_q <= din;
    end
endmodule

// File: rtl/serial_feeder.sv
// serial_feeder: serializes buffered words onto data/data_valid; SERIAL_FEEDER_LSB_FIRST_EN selects LSB-first order
module serial_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_feeder_if.slave  bus
);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]     ALL_BITS = CNT_W'(WIDTH);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP > 0 ? GAP - 1 : 0);

    state_t           state, state_d;
    logic [WIDTH-1:0] sh, sh_nx, hold_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic             hold_full, load, out_bit, more_bits, step_done;

    serial_feeder_hold #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (bus.din),
        .din_valid (bus.din_valid),
        .take      (load),
        .hold_q    (hold_q),
        .hold_full (hold_full),
        .din_ready (bus.din_ready)
    );

`ifdef SERIAL_FEEDER_LSB_FIRST_EN
    assign out_bit = sh[0];
    assign sh_nx   = {1'b0, sh[WIDTH-1:1]};
`else
    assign out_bit = sh[WIDTH-1];
    assign sh_nx   = {sh[WIDTH-2:0], 1'b0};
`endif

    // In SHIFT the counter has not yet counted the bit on the wire
    assign more_bits = (state == ST_SHIFT) ? (bit_cnt != LAST_BIT) : (bit_cnt != ALL_BITS);
    assign step_done = (state == ST_GAP) ? (gap_cnt == GAP_LAST) : (GAP == 0);

    assign bus.data_valid = (state == ST_SHIFT);
    assign bus.data       = (state == ST_SHIFT) && out_bit;
    assign bus.busy       = (state != ST_IDLE) || hold_full;

    // Next state and hold-to-shifter load; a finished word reloads straight from hold
    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            ST_IDLE: begin
                load    = hold_full;
                state_d = hold_full ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT, ST_GAP: begin
                if (step_done) begin
                    load    = !more_bits && hold_full;
                    state_d = (more_bits || hold_full) ? ST_SHIFT : ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // Shifter and bit counter; a load takes priority over the final shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sh      <= hold_q;
            bit_cnt <= '0;
        end else if (state == ST_SHIFT) begin
            sh      <= sh_nx;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Idle-cycle counter, restarted on every cycle outside GAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap_cnt <= '0;
        else
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_CNT_W'(1) : '0;
    end
endmodule

// File: tb/tb_serial_feeder.sv
// tb_serial_feeder: directed vector bench for serial_feeder (GAP=0 and GAP=2 instances)
module tb_serial_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_feeder_if #(.WIDTH(8)) b0 ();
    serial_feeder_if #(.WIDTH(8)) b2 ();

    serial_feeder #(.WIDTH(8), .GAP(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    serial_feeder #(.WIDTH(8), .GAP(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    // Expected emission order, bit 7 leaves first
`ifdef SERIAL_FEEDER_LSB_FIRST_EN
    logic [7:0] e36 = 8'b0110_1100;
    logic [7:0] e01 = 8'b1000_0000;
`else
    logic [7:0] e36 = 8'b0011_0110;
    logic [7:0] e01 = 8'b0000_0001;
`endif
    logic [7:0] ea5 = 8'b1010_0101;
    logic [7:0] ec3 = 8'b1100_0011;

    typedef struct {
        logic [7:0] din;
        logic       vld;
        logic       dv;
        logic       d;
        logic       rdy;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic add_word(input logic [7:0] w, input logic [7:0] e);
        vecs.push_back('{din: w, vld: 1'b1, dv: 1'b0, d: 1'b0, rdy: 1'b1, busy: 1'b0});
        vecs.push_back('{din: 8'h00, vld: 1'b0, dv: 1'b0, d: 1'b0, rdy: 1'b0, busy: 1'b1});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{din: 8'h00, vld: 1'b0, dv: 1'b1, d: e[7-i], rdy: 1'b1, busy: 1'b1});
        vecs.push_back('{din: 8'h00, vld: 1'b0, dv: 1'b0, d: 1'b0, rdy: 1'b1, busy: 1'b0});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dv0"}, b0.data_valid, 0);
        chk({tag, "_d0"}, b0.data, 0);
        chk({tag, "_rdy0"}, b0.din_ready, 1);
        chk({tag, "_busy0"}, b0.busy, 0);
        chk({tag, "_dv2"}, b2.data_valid, 0);
        chk({tag, "_rdy2"}, b2.din_ready, 1);
        chk({tag, "_busy2"}, b2.busy, 0);
    endtask

    initial begin
        logic [3:0] det;
        logic       hit;
        logic       exp_dv;
        logic       exp_d;
        int         k;
        det = 4'h0;
        hit = 1'b0;
        b0.din = '0;
        b0.din_valid = 1'b0;
        b2.din = '0;
        b2.din_valid = 1'b0;
        add_word(8'h36, e36);
        add_word(8'h01, e01);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst_in");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_reset("rst_after");
        @(posedge clk);
        #1;

        // Single words on the GAP=0 instance
        foreach (vecs[i]) begin
            b0.din = vecs[i].din;
            b0.din_valid = vecs[i].vld;
            @(negedge clk);
            chk($sformatf("a%0d_dv", i), b0.data_valid, vecs[i].dv);
            chk($sformatf("a%0d_d", i), b0.data, vecs[i].d);
            chk($sformatf("a%0d_rdy", i), b0.din_ready, vecs[i].rdy);
            chk($sformatf("a%0d_busy", i), b0.busy, vecs[i].busy);
            if (b0.data_valid) begin
                det = {det[2:0], b0.data};
                if (det == 4'b0110)
                    hit = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("det_0110", hit, 1);

        // GAP=2: one bit every third cycle, busy drops after the trailing gap
        for (int c = 0; c < 28; c++) begin
            b2.din = (c == 0) ? 8'hA5 : 8'h00;
            b2.din_valid = (c == 0);
            k = (c - 2) / 3;
            exp_dv = (c >= 2) && ((c - 2) % 3 == 0) && (k < 8);
            exp_d = exp_dv ? ea5[7-k] : 1'b0;
            @(negedge clk);
            chk($sformatf("g%0d_dv", c), b2.data_valid, exp_dv);
            chk($sformatf("g%0d_d", c), b2.data, exp_d);
            chk($sformatf("g%0d_busy", c), b2.busy, (c >= 1) && (c <= 25));
            chk($sformatf("g%0d_rdy", c), b2.din_ready, c != 1);
            @(posedge clk);
            #1;
        end

        // Back-to-back words, with din changing while the buffer is full
        for (int c = 0; c < 20; c++) begin
            b0.din = (c == 0) ? 8'h36 : (c <= 2) ? 8'hC3 : (c <= 7) ? 8'($urandom) : 8'h00;
            b0.din_valid = (c <= 7);
            exp_dv = (c >= 2) && (c <= 17);
            exp_d = !exp_dv ? 1'b0 : (c < 10) ? e36[7-(c-2)] : ec3[7-(c-10)];
            @(negedge clk);
            chk($sformatf("b%0d_dv", c), b0.data_valid, exp_dv);
            chk($sformatf("b%0d_d", c), b0.data, exp_d);
            chk($sformatf("b%0d_rdy", c), b0.din_ready, !((c == 1) || (c >= 3 && c <= 9)));
            chk($sformatf("b%0d_busy", c), b0.busy, (c >= 1) && (c <= 17));
            @(posedge clk);
            #1;
        end

        // Reset during bit 4 of 0xFF with 0x00 buffered
        for (int c = 0; c < 7; c++) begin
            b0.din = (c == 0) ? 8'hFF : 8'h00;
            b0.din_valid = (c == 0) || (c == 2);
            if (c == 6)
                #1 rst_n = 1'b0;
            @(negedge clk);
            if (c == 6)
                chk_reset("r_mid");
            else if (c >= 2) begin
                chk($sformatf("r%0d_dv", c), b0.data_valid, 1);
                chk($sformatf("r%0d_d", c), b0.data, 1);
            end
            if (c == 3)
                chk("r3_rdy", b0.din_ready, 0);
            @(posedge clk);
            #1;
        end
        b0.din_valid = 1'b0;
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("p%0d_dv", c), b0.data_valid, 0);
            chk($sformatf("p%0d_busy", c), b0.busy, 0);
            chk($sformatf("p%0d_rdy", c), b0.din_ready, 1);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_feeder.md
SERIAL_FEEDER -- requirements
Module: serial_feeder

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..16.
REQ-002 Parameter GAP, default 0: idle cycles (data_valid=0) inserted after every serial bit; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a valid word.
REQ-007 din_ready  output  1  holding buffer empty; a word transfers in any cycle where din_valid=1 and din_ready=1.
REQ-008 data  output  1  serial bit to the downstream sequence detector.
REQ-009 data_valid  output  1  data carries a valid bit this cycle.
REQ-010 busy  output  1  high while a word is buffered or being shifted.

Function
REQ-011 The block SHALL hold one buffered word: hold register plus a hold_full flag, with din_ready = !hold_full driven directly from the flag register.
REQ-012 On a transfer, din SHALL be captured into the hold register and hold_full set at the same edge.
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-014 IDLE with hold_full=1: at the next edge, load the shifter from hold, clear hold_full, clear bit_cnt, enter SHIFT.
REQ-015 In SHIFT, data_valid SHALL be 1 and data SHALL equal the current output bit of the shifter.
REQ-016 Each SHIFT cycle SHALL advance the shifter by one bit and increment bit_cnt.
REQ-017 Leaving SHIFT with GAP>0: the FSM SHALL enter GAP for exactly GAP cycles.
REQ-018 Leaving SHIFT with GAP=0, or leaving GAP: if bits remain, enter SHIFT.
REQ-019 If the word is complete and hold_full=1, reload the shifter from hold and enter SHIFT, with no extra bubble.
REQ-020 Otherwise, enter IDLE.
REQ-021 GAP cycles SHALL also follow the last bit of every word.
REQ-022 Whenever data_valid=0, data SHALL be driven 0.
REQ-023 Latency: the first bit of a word accepted in cycle k SHALL appear with data_valid=1 in cycle k+2 when the FSM was idle.
REQ-024 Throughput with GAP=0: back-to-back words SHALL produce continuous data_valid=1 with no bubbles.
REQ-025 A simultaneous transfer and hold-to-shifter move cannot occur, because din_ready is low in the cycle hold empties.
REQ-026 busy SHALL be (state != IDLE) || hold_full.
REQ-027 din_valid deasserting mid-word SHALL NOT disturb the word being shifted.

Reset
REQ-028 While rst_n=0, and in the cycle after release, the outputs SHALL be: state=IDLE, hold_full=0, din_ready=1, data=0, data_valid=0, busy=0.
REQ-029 Reset asserted mid-word SHALL discard the partial word and the buffered word; no further bits of either are emitted.

Configuration
REQ-030 Macro SERIAL_FEEDER_LSB_FIRST_EN SHALL select bit order.
REQ-031 With SERIAL_FEEDER_LSB_FIRST_EN defined, din[0] is sent first.
REQ-032 Without SERIAL_FEEDER_LSB_FIRST_EN, din[WIDTH-1] (MSB) is sent first.
REQ-033 Timing SHALL be identical with and without SERIAL_FEEDER_LSB_FIRST_EN.

Structure
REQ-034 Package serial_feeder_pkg SHALL hold:
- the FSM state typedef (IDLE/SHIFT/GAP);
- WIDTH_DEF=8 and GAP_DEF=0;
- GAP_CNT_W=4.
REQ-035 The holding buffer (hold register, hold_full, din_ready) SHALL be sub-module serial_feeder_hold; the FSM, shifter and counters stay in serial_feeder.

Verification
REQ-036 MSB-first, GAP=0: accept 0x36 in cycle 0 -> data_valid=1 in cycles 2..9, data=0,0,1,1,0,1,1,0; a downstream detector matches "0110".
REQ-037 GAP=2: single word 0xA5 -> valid bits at cycles 2,5,8,...,23, data_valid=0 in between; busy falls after the final GAP.
REQ-038 GAP=0, din_valid held high with 0x36 then 0xC3 -> 16 consecutive valid bits; din_ready low exactly while hold_full=1.
REQ-039 rst_n pulsed low during bit 4 of 0xFF with 0x00 buffered -> all outputs return to reset values immediately; no bits emitted after release.
REQ-040 SERIAL_FEEDER_LSB_FIRST_EN defined, 0x01 -> first valid bit 1, then seven 0s.
REQ-041 din_valid=1 while din_ready=0 for 5 cycles with a changing din -> only the value present in the accept cycle is serialized.
